// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame constants and receiver state encoding
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;
  localparam int MID_START  = 7;

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - oversample tick generator, one pulse every DIV clocks
module uart_baud_tick #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  output logic o_tick
);

  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Free-running 0..DIV-1 divider; clearing realigns the tick phase to a line edge
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign o_tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with 16x oversampling and stop-bit check
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_rxd,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam logic [3:0] START_SAMPLE = 4'(MID_START);
  localparam logic [3:0] BIT_SAMPLE   = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] LAST_BIT     = 3'(DATA_BITS - 1);

  logic       rxd_m, rxd_s;
  logic       tick, tick_clear;
  rx_state_t  state, state_nxt;
  logic [3:0] scnt, scnt_nxt;
  logic [2:0] bitcnt, bitcnt_nxt;
  logic [7:0] shreg, shreg_nxt;
  logic       armed, armed_nxt;
  logic [7:0] data_nxt;
  logic       valid_nxt, ferr_nxt;

  uart_baud_tick #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_clear(tick_clear),
    .o_tick (tick)
  );

  // Two-flop synchronizer; reset to the idle (high) line level
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= i_rxd;
      rxd_s <= rxd_m;
    end
  end

  // Next-state, counters and output pulses; counters only move on a tick
  always_comb begin
    state_nxt  = state;
    scnt_nxt   = scnt;
    bitcnt_nxt = bitcnt;
    shreg_nxt  = shreg;
    armed_nxt  = armed;
    data_nxt   = o_data;
    valid_nxt  = 1'b0;
    ferr_nxt   = 1'b0;
    tick_clear = 1'b0;
    case (state)
      IDLE: begin
        if (rxd_s) begin
          armed_nxt = 1'b1;
        end else if (armed) begin
          state_nxt  = START;
          scnt_nxt   = 4'd0;
          tick_clear = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          if (scnt == START_SAMPLE) begin
            if (!rxd_s) begin
              state_nxt  = DATA;
              scnt_nxt   = 4'd0;
              bitcnt_nxt = 3'd0;
            end else begin
              // Line went back high before mid-start: treat as noise
              state_nxt = IDLE;
            end
          end else begin
            scnt_nxt = scnt + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          scnt_nxt = scnt + 4'd1;
          if (scnt == BIT_SAMPLE) begin
            shreg_nxt  = {rxd_s, shreg[7:1]};
            bitcnt_nxt = bitcnt + 3'd1;
            if (bitcnt == LAST_BIT) begin
              state_nxt = STOP;
            end
          end
        end
      end
      STOP: begin
        if (tick) begin
          scnt_nxt = scnt + 4'd1;
          if (scnt == BIT_SAMPLE) begin
            state_nxt = IDLE;
            if (rxd_s) begin
              data_nxt  = shreg;
              valid_nxt = 1'b1;
              armed_nxt = 1'b1;
            end else begin
              // Disarm so a held-low break cannot start a phantom frame
              ferr_nxt  = 1'b1;
              armed_nxt = 1'b0;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= IDLE;
      scnt        <= 4'd0;
      bitcnt      <= 3'd0;
      shreg       <= 8'h00;
      armed       <= 1'b0;
      o_data      <= 8'h00;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      scnt        <= scnt_nxt;
      bitcnt      <= bitcnt_nxt;
      shreg       <= shreg_nxt;
      armed       <= armed_nxt;
      o_data      <= data_nxt;
      o_valid     <= valid_nxt;
      o_frame_err <= ferr_nxt;
    end
  end

  assign o_busy = (state != IDLE);

endmodule
